// File: rtl/csv_field_tokenizer.sv
// Streaming CSV tokenizer: bytes in, tagged DATA/FIELD_END/RECORD_END/ERROR beats out.
// Handles quoted fields, doubled-quote escapes and error recovery up to the next LF.
module csv_field_tokenizer #(
  parameter logic [7:0] SEP           = 8'h2C,
  parameter logic [7:0] QUOTE         = 8'h22,
  parameter int         MAX_FIELD_LEN = 256,
  parameter int         FIELD_IDX_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic [1:0]             out_kind,
  output logic [FIELD_IDX_W-1:0] out_field_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_sticky,
  output logic [31:0]            record_count
);

  localparam int LEN_W = $clog2(MAX_FIELD_LEN + 1);
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FIELD_LEN);
  localparam logic [FIELD_IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_START, S_UNQ, S_QUOTED, S_QSEEN, S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    K_DATA, K_FEND, K_REND, K_ERR
  } kind_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [FIELD_IDX_W-1:0] idx_q, idx_d;
  logic                   ov_q, ov_d;
  logic [7:0]             od_q, od_d;
  kind_t                  ok_q, ok_d;
  logic [FIELD_IDX_W-1:0] oi_q, oi_d;
  logic                   err_q, err_d;
  logic [31:0]            rec_q, rec_d;

  logic       accept;
  logic       beat_v;
  kind_t      beat_k;
  logic [7:0] beat_d;
  logic       is_q, is_sep, is_lf, is_cr;

  assign in_ready      = !ov_q || out_ready;
  assign accept        = in_valid && in_ready;
  assign is_q          = (in_data == QUOTE);
  assign is_sep        = (in_data == SEP);
  assign is_lf         = (in_data == LF);
  assign is_cr         = (in_data == CR);
  assign out_valid     = ov_q;
  assign out_data      = od_q;
  assign out_kind      = ok_q;
  assign out_field_idx = oi_q;
  assign err_sticky    = err_q;
  assign record_count  = rec_q;

  // Classify the accepted byte, form the beat, advance state and counters.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ok_d    = ok_q;
    oi_d    = oi_q;
    err_d   = err_q;
    rec_d   = rec_q;
    beat_v  = 1'b0;
    beat_k  = K_DATA;
    beat_d  = 8'h00;

    if (accept) begin
      unique case (state_q)
        S_START: begin
          unique case (1'b1)
            is_q:   state_d = S_QUOTED;
            is_sep: begin beat_v = 1'b1; beat_k = K_FEND; end
            is_lf:  begin beat_v = 1'b1; beat_k = K_REND; end
            is_cr:  ;
            default: begin
              beat_v  = 1'b1;
              beat_d  = in_data;
              state_d = S_UNQ;
            end
          endcase
        end
        S_UNQ: begin
          unique case (1'b1)
            is_sep: begin beat_v = 1'b1; beat_k = K_FEND; end
            is_lf:  begin beat_v = 1'b1; beat_k = K_REND; end
            is_cr:  ;
            is_q:   begin beat_v = 1'b1; beat_k = K_ERR; end
            default: begin beat_v = 1'b1; beat_d = in_data; end
          endcase
        end
        S_QUOTED: begin
          if (is_q) begin
            state_d = S_QSEEN;
          end else begin
            beat_v = 1'b1;
            beat_d = in_data;
          end
        end
        S_QSEEN: begin
          unique case (1'b1)
            is_q: begin
              beat_v  = 1'b1;
              beat_d  = QUOTE;
              state_d = S_QUOTED;
            end
            is_sep: begin beat_v = 1'b1; beat_k = K_FEND; end
            is_lf:  begin beat_v = 1'b1; beat_k = K_REND; end
            is_cr:  ;
            default: begin beat_v = 1'b1; beat_k = K_ERR; end
          endcase
        end
        S_DRAIN: begin
          if (is_lf) begin
            state_d = S_START;
            idx_d   = '0;
            len_d   = '0;
          end
        end
        default: state_d = S_START;
      endcase
    end

    // A data byte past the field limit becomes an error marker.
    if (beat_v && beat_k == K_DATA && len_q == LEN_MAX) begin
      beat_k = K_ERR;
      beat_d = 8'h00;
    end

    if (beat_v) begin
      unique case (beat_k)
        K_DATA: len_d = len_q + LEN_W'(1);
        K_FEND: begin
          len_d   = '0;
          state_d = S_START;
          if (idx_q != IDX_MAX) idx_d = idx_q + FIELD_IDX_W'(1);
        end
        K_REND: begin
          len_d   = '0;
          idx_d   = '0;
          state_d = S_START;
          rec_d   = rec_q + 32'd1;
        end
        default: begin
          len_d   = '0;
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end
      endcase
    end

    if (in_ready) begin
      ov_d = beat_v;
      od_d = beat_d;
      ok_d = beat_v ? beat_k : K_DATA;
      oi_d = idx_q;
    end
  end

  // State, counters and the single output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_START;
      len_q   <= '0;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= 8'h00;
      ok_q    <= K_DATA;
      oi_q    <= '0;
      err_q   <= 1'b0;
      rec_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ok_q    <= ok_d;
      oi_q    <= oi_d;
      err_q   <= err_d;
      rec_q   <= rec_d;
    end
  end

endmodule

// File: tb/tb_csv_field_tokenizer.sv
// Self-checking bench for csv_field_tokenizer: directed scenarios plus a
// randomized stalled stream against a field-level reference parser.
module tb_csv_field_tokenizer;

  localparam int MAXL = 5;
  localparam int IDXW = 2;
  localparam int BW   = 10 + IDXW;
  localparam logic [7:0] QU = 8'h22;
  localparam logic [7:0] SP = 8'h2C;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  typedef logic [7:0] bq_t[$];
  typedef logic [BW-1:0] beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      out_data;
  logic [1:0]      out_kind;
  logic [IDXW-1:0] out_field_idx;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            err_sticky;
  logic [31:0]     record_count;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t got[$];
  beat_t mq[$];
  beat_t ex[$];
  int    got_cyc[$];
  int    stall_err;
  bit    timed_out;
  int    m_idx;
  int    m_len;

  csv_field_tokenizer #(
    .MAX_FIELD_LEN(MAXL),
    .FIELD_IDX_W(IDXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_kind(out_kind),
    .out_field_idx(out_field_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sticky(err_sticky),
    .record_count(record_count)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(logic [1:0] k, logic [7:0] d, int i);
    logic [IDXW-1:0] ii;
    ii = i[IDXW-1:0];
    return {k, d, ii};
  endfunction

  function automatic bq_t str2q(string st);
    bq_t q;
    for (int k = 0; k < st.len(); k++) q.push_back(st[k]);
    return q;
  endfunction

  // Reference parser: walks field by field over the whole byte list.
  function automatic void m_push(logic [1:0] k, logic [7:0] d);
    mq.push_back(mk(k, d, m_idx));
  endfunction

  function automatic bit m_data(logic [7:0] c);
    if (m_len == MAXL) begin
      m_push(2'd3, 8'h00);
      return 1'b1;
    end
    m_push(2'd0, c);
    m_len++;
    return 1'b0;
  endfunction

  task automatic model(input bq_t s);
    int i = 0;
    int n = s.size();
    logic [7:0] c;
    mq.delete();
    m_idx = 0;
    m_len = 0;
    while (i < n) begin
      int fate = 0;
      while (i < n && s[i] == CR) i++;
      if (i >= n) break;
      if (s[i] == QU) begin
        i++;
        while (i < n && fate == 0) begin
          c = s[i]; i++;
          if (c != QU) begin
            if (m_data(c)) fate = 3;
          end else begin
            while (i < n && s[i] == CR) i++;
            if (i >= n) break;
            c = s[i]; i++;
            if (c == QU) begin
              if (m_data(c)) fate = 3;
            end else if (c == SP) fate = 1;
            else if (c == LF) fate = 2;
            else begin m_push(2'd3, 8'h00); fate = 3; end
          end
        end
      end else begin
        while (i < n && fate == 0) begin
          c = s[i]; i++;
          if (c == CR) ;
          else if (c == SP) fate = 1;
          else if (c == LF) fate = 2;
          else if (c == QU) begin m_push(2'd3, 8'h00); fate = 3; end
          else if (m_data(c)) fate = 3;
        end
      end
      if (fate == 1) begin
        m_push(2'd1, 8'h00);
        if (m_idx < (1 << IDXW) - 1) m_idx++;
        m_len = 0;
      end else if (fate == 2) begin
        m_push(2'd2, 8'h00);
        m_idx = 0;
        m_len = 0;
      end else if (fate == 3) begin
        while (i < n && s[i] != LF) i++;
        if (i < n) i++;
        m_idx = 0;
        m_len = 0;
      end
    end
  endtask

  function automatic bq_t gen_stream(int nrec);
    bq_t q;
    for (int r = 0; r < nrec; r++) begin
      int nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        int t = $urandom_range(0, 9);
        int len = $urandom_range(0, 7);
        if (f > 0) q.push_back(SP);
        if (t < 5) begin
          for (int k = 0; k < len; k++) begin
            q.push_back(8'h61 + 8'($urandom_range(0, 25)));
            if ($urandom_range(0, 19) == 0) q.push_back(CR);
          end
        end else if (t == 5) begin
          q.push_back(8'h61); q.push_back(QU); q.push_back(8'h62);
        end else begin
          q.push_back(QU);
          for (int k = 0; k < len; k++) begin
            int c = $urandom_range(0, 5);
            if (c < 3) q.push_back(8'h61 + 8'($urandom_range(0, 25)));
            else if (c == 3) q.push_back(SP);
            else if (c == 4) q.push_back(LF);
            else begin q.push_back(QU); q.push_back(QU); end
          end
          q.push_back(QU);
          if (t == 9) q.push_back(8'h7A);
          else if ($urandom_range(0, 4) == 0) q.push_back(CR);
        end
      end
      if ($urandom_range(0, 3) == 0) q.push_back(CR);
      q.push_back(LF);
    end
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives bytes and collects beats, one handshake decision per cycle.
  task automatic run_stream(input bq_t s, input int stall_pct, input int gap_pct);
    int i = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [BW:0] held = '0;
    got.delete(); got_cyc.delete();
    stall_err = 0; timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (hold && ({out_valid, out_kind, out_data, out_field_idx} !== held)) stall_err++;
      if (i >= s.size() && !out_valid) break;
      if (cyc >= 30000) begin timed_out = 1'b1; break; end
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (i < s.size() && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1; in_data = s[i];
      end else begin
        in_valid = 1'b0; in_data = 8'h00;
      end
      #1;
      hold = out_valid && !out_ready;
      held = {out_valid, out_kind, out_data, out_field_idx};
      if (out_valid && out_ready) begin
        got.push_back({out_kind, out_data, out_field_idx});
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) i++;
      cyc++;
    end
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_kind, out_data, out_field_idx, err_sticky} !== {1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outs got v=%b r=%b k=%0d d=%h i=%0d e=%b want v=0 r=1 k=0 d=00 i=0 e=0",
               out_valid, in_ready, out_kind, out_data, out_field_idx, err_sticky);
    end
    n_cmp++;
    if (record_count !== 32'd0) begin n_bad++; $display("FAIL reset_rc got %0d want 0", record_count); end
  endtask

  task automatic test_basic();
    do_reset();
    ex = '{mk(0, "a", 0), mk(0, "b", 0), mk(1, 0, 0), mk(0, "c", 1), mk(2, 0, 1)};
    run_stream(str2q("ab,c\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL basic_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j] || got_cyc[j] != j + 1) begin
        n_bad++; $display("FAIL basic_beat%0d got %h want %h at cycle %0d", j, got[j], ex[j], j + 1);
      end
    end
    n_cmp++;
    if (record_count !== 32'd1) begin n_bad++; $display("FAIL basic_rc got %0d want 1", record_count); end
  endtask

  task automatic test_quoted();
    do_reset();
    ex = '{mk(0, "x", 0), mk(0, SP, 0), mk(0, QU, 0), mk(0, "y", 0), mk(0, QU, 0), mk(1, 0, 0), mk(2, 0, 1)};
    run_stream(str2q("\"x,\"\"y\"\"\",\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL quoted_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j]) begin n_bad++; $display("FAIL quoted_beat%0d got %h want %h", j, got[j], ex[j]); end
    end
  endtask

  task automatic test_error();
    do_reset();
    ex = '{mk(0, "a", 0), mk(3, 0, 0), mk(0, "c", 0), mk(2, 0, 0)};
    run_stream(str2q("a\"b\nc\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL error_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j]) begin n_bad++; $display("FAIL error_beat%0d got %h want %h", j, got[j], ex[j]); end
    end
    n_cmp++;
    if (err_sticky !== 1'b1 || record_count !== 32'd1) begin
      n_bad++; $display("FAIL error_flags got e=%b rc=%0d want e=1 rc=1", err_sticky, record_count);
    end
  endtask

  task automatic test_maxlen();
    do_reset();
    ex = '{mk(0, "a", 0), mk(0, "b", 0), mk(0, "c", 0), mk(0, "d", 0), mk(0, "e", 0),
           mk(3, 0, 0), mk(0, "z", 0), mk(2, 0, 0)};
    run_stream(str2q("abcdef,gh\nz\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL maxlen_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j]) begin n_bad++; $display("FAIL maxlen_beat%0d got %h want %h", j, got[j], ex[j]); end
    end
  endtask

  task automatic test_idx_sat();
    do_reset();
    ex = '{mk(0, "a", 0), mk(1, 0, 0), mk(0, "b", 1), mk(1, 0, 1), mk(0, "c", 2), mk(1, 0, 2),
           mk(0, "d", 3), mk(1, 0, 3), mk(0, "e", 3), mk(2, 0, 3), mk(2, 0, 0)};
    run_stream(str2q("a,b,c,d,e\n\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL idxsat_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j]) begin n_bad++; $display("FAIL idxsat_beat%0d got %h want %h", j, got[j], ex[j]); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t s;
    beat_t ref_run[$];
    logic [31:0] rc0;
    int n_re = 0;
    do_reset();
    s = gen_stream(100);
    model(s);
    foreach (mq[j]) if (mq[j][BW-1 -: 2] == 2'd2) n_re++;
    rc0 = record_count;
    run_stream(s, 0, 0);
    ref_run = got;
    n_cmp++;
    if (timed_out || got.size() != mq.size()) begin n_bad++; $display("FAIL rand_len got %0d want %0d", got.size(), mq.size()); end
    foreach (mq[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== mq[j]) begin n_bad++; $display("FAIL rand_beat%0d got %h want %h", j, got[j], mq[j]); end
    end
    run_stream(s, 40, 25);
    n_cmp++;
    if (timed_out || got.size() != ref_run.size()) begin
      n_bad++; $display("FAIL stall_len got %0d want %0d", got.size(), ref_run.size());
    end
    foreach (ref_run[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ref_run[j]) begin n_bad++; $display("FAIL stall_beat%0d got %h want %h", j, got[j], ref_run[j]); end
    end
    n_cmp++;
    if (stall_err != 0) begin n_bad++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
    n_cmp++;
    if (record_count !== rc0 + 32'(2 * n_re)) begin
      n_bad++; $display("FAIL stall_rc got %0d want %0d", record_count, rc0 + 32'(2 * n_re));
    end
  endtask

  task automatic test_reset_mid();
    run_stream(str2q("x\"\n"), 0, 0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = QU;
    @(negedge clk);
    in_data = "a";
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || err_sticky !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pending got v=%b e=%b want v=1 e=1", out_valid, err_sticky);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, err_sticky, out_field_idx, record_count} !== {1'b0, 1'b0, 2'd0, 32'd0}) begin
      n_bad++; $display("FAIL midrst_clear got v=%b e=%b i=%0d rc=%0d want 0 0 0 0",
                        out_valid, err_sticky, out_field_idx, record_count);
    end
    ex = '{mk(0, "z", 0), mk(2, 0, 0)};
    run_stream(str2q("z\n"), 0, 0);
    n_cmp++;
    if (timed_out || got.size() != ex.size()) begin n_bad++; $display("FAIL midrst_len got %0d want %0d", got.size(), ex.size()); end
    foreach (ex[j]) begin
      n_cmp++;
      if (j >= got.size() || got[j] !== ex[j]) begin n_bad++; $display("FAIL midrst_beat%0d got %h want %h", j, got[j], ex[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quoted();
    test_error();
    test_maxlen();
    test_idx_sat();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
